mesh_switch_2x2: RTL and testbench

Buffered, self-routing 2x2 switch element for the multistage interconnect network. It is the next generation of the registered 2x2 crossbar cell. Each input has a valid/ready handshake and a DEPTH-entry FIFO. Each word is routed by one bit of its own payload. Output contention is resolved by per-output round-robin arbitration, and each output is a single registered stage with valid/ready backpressure, so stages can be chained into butterfly/omega networks without global flow control.

---
 rtl/mins_pkg.sv | 19 +
 rtl/mesh_switch_2x2_if.sv | 38 +++
 rtl/mins_sync_fifo.sv | 67 ++++++
 rtl/mesh_switch_2x2.sv | 126 ++++++++++++
 tb/tb_mesh_switch_2x2.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mins_pkg.sv
// Shared definitions for the multistage interconnect switch cells.
// Port indices, route decode and default sizing for network generators.
package mins_pkg;

  localparam int LEFT      = 0;
  localparam int RIGHT     = 1;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    PORT_L = 1'b0,
    PORT_R = 1'b1
  } port_e;

  function automatic port_e route_port(input logic sel);
    return sel ? PORT_R : PORT_L;
  endfunction

endpackage

// File: rtl/mesh_switch_2x2_if.sv
// Payload/handshake bundle of the 2x2 switch element.
// master drives the inputs and output readies; slave is the switch.
interface mesh_switch_2x2_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;
  logic             left_in_valid;
  logic             right_in_valid;
  logic             left_in_ready;
  logic             right_in_ready;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             left_out_valid;
  logic             right_out_valid;
  logic             left_out_ready;
  logic             right_out_ready;

  modport master (
    output left_in, right_in,
    output left_in_valid, right_in_valid,
    output left_out_ready, right_out_ready,
    input  left_in_ready, right_in_ready,
    input  left_out, right_out,
    input  left_out_valid, right_out_valid
  );

  modport slave (
    input  left_in, right_in,
    input  left_in_valid, right_in_valid,
    input  left_out_ready, right_out_ready,
    output left_in_ready, right_in_ready,
    output left_out, right_out,
    output left_out_valid, right_out_valid
  );

endinterface

// File: rtl/mins_sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy count.
// Pointers wrap modulo DEPTH (power of two).
module mins_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  // next pointers and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));
  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/mesh_switch_2x2.sv
// Buffered self-routing 2x2 switch: two input FIFOs,
// per-output round-robin arbitration and one output register each.
module mesh_switch_2x2
  import mins_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ROUTE_BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mesh_switch_2x2_if.slave sw
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_d  [2];
  logic [WIDTH-1:0] head  [2];
  logic [WIDTH-1:0] out_q [2];
  logic [WIDTH-1:0] out_d [2];
  logic [CW-1:0]    cnt   [2];

  logic [1:0] in_v, push, pop, full, empty;
  logic [1:0] vld, dst, o_rdy;
  logic [1:0] out_v_q, out_v_d;
  logic [1:0] prio_q, prio_d;
  logic [1:0] load, sel, can_ld;
  logic [1:0][1:0] want;

  assign in_d[LEFT]   = sw.left_in;
  assign in_d[RIGHT]  = sw.right_in;
  assign in_v[LEFT]   = sw.left_in_valid;
  assign in_v[RIGHT]  = sw.right_in_valid;
  assign o_rdy[LEFT]  = sw.left_out_ready;
  assign o_rdy[RIGHT] = sw.right_out_ready;

  assign sw.left_in_ready   = !full[LEFT];
  assign sw.right_in_ready  = !full[RIGHT];
  assign sw.left_out        = out_q[LEFT];
  assign sw.right_out       = out_q[RIGHT];
  assign sw.left_out_valid  = out_v_q[LEFT];
  assign sw.right_out_valid = out_v_q[RIGHT];

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    assign push[i] = in_v[i] && !full[i];
    assign vld[i]  = !empty[i];
    assign dst[i]  = route_port(head[i][ROUTE_BIT]);

    mins_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .data_i  (in_d[i]),
      .pop_i   (pop[i]),
      .data_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (cnt[i])
    );

    a_cnt_range: assert property (
      @(posedge clk) disable iff (!rst_n) cnt[i] <= CW'(DEPTH));
  end

  // per-output round-robin grant; loser keeps its head
  always_comb begin
    want   = '0;
    load   = '0;
    sel    = '0;
    can_ld = '0;
    pop    = '0;
    prio_d = prio_q;
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 2; i++) begin
        want[o][i] = vld[i] && (dst[i] == o[0]);
      end
      can_ld[o] = !out_v_q[o] || o_rdy[o];
      if (can_ld[o]) begin
        unique case (want[o])
          2'b11: begin
            sel[o]    = prio_q[o];
            prio_d[o] = !prio_q[o];
          end
          2'b01:   sel[o] = 1'b0;
          2'b10:   sel[o] = 1'b1;
          default: ;
        endcase
        load[o] = |want[o];
      end
      if (load[o]) pop[sel[o]] = 1'b1;
    end
  end

  // output register load / consume
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      out_d[o]   = out_q[o];
      out_v_d[o] = out_v_q[o];
      if (load[o]) begin
        out_d[o]   = head[sel[o]];
        out_v_d[o] = 1'b1;
      end else if (o_rdy[o]) begin
        out_v_d[o] = 1'b0;
      end
    end
  end

  // output and priority state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q[0] <= '0;
      out_q[1] <= '0;
      out_v_q  <= '0;
      prio_q   <= '0;
    end else begin
      out_q[0] <= out_d[0];
      out_q[1] <= out_d[1];
      out_v_q  <= out_v_d;
      prio_q   <= prio_d;
    end
  end

endmodule

// File: tb/tb_mesh_switch_2x2.sv
// Bench for mesh_switch_2x2: directed scenarios on the default
// configuration plus a randomized scoreboard across three configurations.
module tb_mesh_switch_2x2;

  localparam int W  [3] = '{64, 8, 128};
  localparam int RB [3] = '{0, 7, 0};
  localparam int TB [3] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] id   [3][2];
  logic         iv   [3][2];
  logic         ordy [3][2];
  wire  [127:0] od   [3][2];
  wire          ov   [3][2];
  wire          ir   [3][2];

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q [3][2][2][$];

  mesh_switch_2x2_if #(.WIDTH(64))  b0 ();
  mesh_switch_2x2_if #(.WIDTH(8))   b1 ();
  mesh_switch_2x2_if #(.WIDTH(128)) b2 ();

  mesh_switch_2x2 #(.WIDTH(64), .DEPTH(4), .ROUTE_BIT(0))
    u0 (.clk(clk), .rst_n(rst_n), .sw(b0));
  mesh_switch_2x2 #(.WIDTH(8), .DEPTH(2), .ROUTE_BIT(7))
    u1 (.clk(clk), .rst_n(rst_n), .sw(b1));
  mesh_switch_2x2 #(.WIDTH(128), .DEPTH(16), .ROUTE_BIT(0))
    u2 (.clk(clk), .rst_n(rst_n), .sw(b2));

  assign b0.left_in         = id[0][0][63:0];
  assign b0.right_in        = id[0][1][63:0];
  assign b0.left_in_valid   = iv[0][0];
  assign b0.right_in_valid  = iv[0][1];
  assign b0.left_out_ready  = ordy[0][0];
  assign b0.right_out_ready = ordy[0][1];
  assign od[0][0] = 128'(b0.left_out);
  assign od[0][1] = 128'(b0.right_out);
  assign ov[0][0] = b0.left_out_valid;
  assign ov[0][1] = b0.right_out_valid;
  assign ir[0][0] = b0.left_in_ready;
  assign ir[0][1] = b0.right_in_ready;

  assign b1.left_in         = id[1][0][7:0];
  assign b1.right_in        = id[1][1][7:0];
  assign b1.left_in_valid   = iv[1][0];
  assign b1.right_in_valid  = iv[1][1];
  assign b1.left_out_ready  = ordy[1][0];
  assign b1.right_out_ready = ordy[1][1];
  assign od[1][0] = 128'(b1.left_out);
  assign od[1][1] = 128'(b1.right_out);
  assign ov[1][0] = b1.left_out_valid;
  assign ov[1][1] = b1.right_out_valid;
  assign ir[1][0] = b1.left_in_ready;
  assign ir[1][1] = b1.right_in_ready;

  assign b2.left_in         = id[2][0];
  assign b2.right_in        = id[2][1];
  assign b2.left_in_valid   = iv[2][0];
  assign b2.right_in_valid  = iv[2][1];
  assign b2.left_out_ready  = ordy[2][0];
  assign b2.right_out_ready = ordy[2][1];
  assign od[2][0] = b2.left_out;
  assign od[2][1] = b2.right_out;
  assign ov[2][0] = b2.left_out_valid;
  assign ov[2][1] = b2.right_out_valid;
  assign ir[2][0] = b2.left_in_ready;
  assign ir[2][1] = b2.right_in_ready;

  function automatic logic [127:0] mask(input int k);
    return (128'(1) << W[k]) - 128'(1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 2; s++) begin
        iv[k][s]   = 1'b0;
        id[k][s]   = '0;
        ordy[k][s] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ir[0][s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d] got %b want 1", s, ir[0][s]);
      end
      checks++;
      if (ov[0][s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid[%0d] got %b want 0", s, ov[0][s]);
      end
      checks++;
      if (od[0][s] !== 128'h0) begin
        errors++;
        $display("FAIL reset_out_data[%0d] got %h want 0", s, od[0][s]);
      end
    end
  endtask

  task automatic pair_route(input string nm,
                            input logic [127:0] l, input logic [127:0] r,
                            input logic [127:0] el, input logic [127:0] er);
    id[0][0] = l;
    id[0][1] = r;
    iv[0][0] = 1'b1;
    iv[0][1] = 1'b1;
    tick();
    iv[0][0] = 1'b0;
    iv[0][1] = 1'b0;
    checks++;
    if (ov[0][0] !== 1'b0 || ov[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL %s_early valid got %b%b want 00", nm, ov[0][0], ov[0][1]);
    end
    tick();
    checks++;
    if (ov[0][0] !== 1'b1 || od[0][0] !== el) begin
      errors++;
      $display("FAIL %s_left got v=%b %h want v=1 %h", nm, ov[0][0], od[0][0], el);
    end
    checks++;
    if (ov[0][1] !== 1'b1 || od[0][1] !== er) begin
      errors++;
      $display("FAIL %s_right got v=%b %h want v=1 %h", nm, ov[0][1], od[0][1], er);
    end
    tick();
    checks++;
    if (ov[0][0] !== 1'b0 || ov[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL %s_oneshot valid got %b%b want 00", nm, ov[0][0], ov[0][1]);
    end
  endtask

  task automatic test_straight();
    pair_route("straight", 128'h10, 128'h21, 128'h10, 128'h21);
  endtask

  task automatic test_crossover();
    pair_route("crossover", 128'h31, 128'h40, 128'h40, 128'h31);
  endtask

  task automatic test_contention();
    int ln, rn, n, rbad;
    logic al, ar;
    logic [127:0] e;
    ln = 0; rn = 0; n = 0; rbad = 0;
    id[0][0] = 128'h0;
    id[0][1] = 128'h100;
    iv[0][0] = 1'b1;
    iv[0][1] = 1'b1;
    repeat (20) begin
      al = ir[0][0];
      ar = ir[0][1];
      tick();
      if (al) begin ln += 2; id[0][0] = 128'(ln); end
      if (ar) begin rn += 2; id[0][1] = 128'(256 + rn); end
      if (ov[0][1]) rbad++;
      if (ov[0][0] && n < 8) begin
        e = (n % 2 == 0) ? 128'((n / 2) * 2) : 128'(256 + (n / 2) * 2);
        checks++;
        if (od[0][0] !== e) begin
          errors++;
          $display("FAIL contention_seq[%0d] got %h want %h", n, od[0][0], e);
        end
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL contention_count got %0d want 8", n);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL contention_right_valid got %0d cycles want 0", rbad);
    end
    iv[0][0] = 1'b0;
    iv[0][1] = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_backpressure();
    int acc, unstable;
    logic a;
    acc = 0; unstable = 0;
    ordy[0][0] = 1'b0;
    id[0][0] = 128'h200;
    iv[0][0] = 1'b1;
    repeat (10) begin
      a = ir[0][0];
      tick();
      if (a) begin acc++; id[0][0] = 128'(512 + 2 * acc); end
      if (ov[0][0] && od[0][0] !== 128'h200) unstable++;
    end
    iv[0][0] = 1'b0;
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 5", acc);
    end
    checks++;
    if (ir[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got %b want 0", ir[0][0]);
    end
    checks++;
    if (unstable != 0 || ov[0][0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable v=%b want 0 v=1", unstable, ov[0][0]);
    end
    ordy[0][0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[0][0] !== 1'b1 || od[0][0] !== 128'(512 + 2 * i)) begin
        errors++;
        $display("FAIL bp_drain[%0d] got v=%b %h want v=1 %h",
                 i, ov[0][0], od[0][0], 128'(512 + 2 * i));
      end
      tick();
    end
    checks++;
    if (ov[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b want 0", ov[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    int quiet;
    ordy[0][0] = 1'b0;
    ordy[0][1] = 1'b0;
    iv[0][0] = 1'b1;
    iv[0][1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id[0][0] = 128'(768 + 2 * i);
      id[0][1] = 128'(1025 + 2 * i);
      tick();
    end
    iv[0][0] = 1'b0;
    iv[0][1] = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (ov[0][s] !== 1'b0 || od[0][s] !== 128'h0) begin
        errors++;
        $display("FAIL rstmid_async[%0d] got v=%b %h want v=0 0", s, ov[0][s], od[0][s]);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    ordy[0][0] = 1'b1;
    ordy[0][1] = 1'b1;
    tick();
    checks++;
    if (ir[0][0] !== 1'b1 || ir[0][1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b%b want 11", ir[0][0], ir[0][1]);
    end
    quiet = 0;
    repeat (4) begin
      tick();
      if (ov[0][0] || ov[0][1]) quiet++;
    end
    checks++;
    if (quiet != 0) begin
      errors++;
      $display("FAIL rstmid_emitted got %0d cycles want 0", quiet);
    end
    id[0][0] = 128'h500;
    iv[0][0] = 1'b1;
    tick();
    iv[0][0] = 1'b0;
    checks++;
    if (ov[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_lat1 got v=%b want 0", ov[0][0]);
    end
    tick();
    checks++;
    if (ov[0][0] !== 1'b1 || od[0][0] !== 128'h500) begin
      errors++;
      $display("FAIL rstmid_lat2 got v=%b %h want v=1 500", ov[0][0], od[0][0]);
    end
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [127:0] w, e;
    logic [127:0] ow [3][2];
    logic fin [3][2];
    logic fout [3][2];
    int seq [3][2];
    int src, rt;
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 2; s++) seq[k][s] = 0;
    for (int c = 0; c < cycles + 80; c++) begin
      for (int k = 0; k < 3; k++) begin
        for (int s = 0; s < 2; s++) begin
          if (c < cycles) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            w[TB[k]] = s[0];
            if (k == 1) w[6:1] = seq[k][s][5:0];
            id[k][s]   = w & mask(k);
            iv[k][s]   = ($urandom_range(0, 3) != 0);
            ordy[k][s] = ($urandom_range(0, 3) != 0);
          end else begin
            iv[k][s]   = 1'b0;
            ordy[k][s] = 1'b1;
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        for (int s = 0; s < 2; s++) begin
          fin[k][s]  = iv[k][s] && ir[k][s];
          fout[k][s] = ov[k][s] && ordy[k][s];
          ow[k][s]   = od[k][s];
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        for (int o = 0; o < 2; o++) begin
          if (fout[k][o]) begin
            src = int'(ow[k][o][TB[k]]);
            rt  = int'(ow[k][o][RB[k]]);
            checks++;
            if (rt != o) begin
              errors++;
              $display("FAIL rnd_route u%0d out%0d got %h route %0d", k, o, ow[k][o], rt);
            end
            checks++;
            if (exp_q[k][src][o].size() == 0) begin
              errors++;
              $display("FAIL rnd_spurious u%0d out%0d got %h want none", k, o, ow[k][o]);
            end else begin
              e = exp_q[k][src][o].pop_front();
              if (e !== ow[k][o]) begin
                errors++;
                $display("FAIL rnd_order u%0d out%0d got %h want %h", k, o, ow[k][o], e);
              end
            end
          end
        end
        for (int s = 0; s < 2; s++) begin
          if (fin[k][s]) begin
            exp_q[k][s][int'(id[k][s][RB[k]])].push_back(id[k][s]);
            seq[k][s]++;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 2; s++)
        for (int o = 0; o < 2; o++) begin
          checks++;
          if (exp_q[k][s][o].size() != 0) begin
            errors++;
            $display("FAIL rnd_loss u%0d in%0d out%0d got %0d left want 0",
                     k, s, o, exp_q[k][s][o].size());
          end
        end
  endtask

  initial begin
    idle();
    test_reset();
    test_straight();
    test_crossover();
    test_contention();
    test_backpressure();
    test_reset_mid();
    idle();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
